mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: width of all address buses.
REQ-002 SHALL have parameter DATA_W, default 32: width of all data buses. Byte-enable width is DATA_W/8.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum BUSY cycles allowed without m_ready. Range 1..255.
REQ-004 SHALL have port clk, input, 1: single clock. All state changes on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-high (1 = reset asserted).
REQ-006 SHALL have port if_req, input, 1: instruction-fetch request, level. Held until if_ack.
REQ-007 SHALL have port if_addr, input, ADDR_W: fetch address.
REQ-008 SHALL have port if_rdata, output, DATA_W: fetched word, valid when if_ack=1.
REQ-009 SHALL have port if_ack, output, 1: one-cycle completion pulse for fetch.
REQ-010 SHALL have port d_req, input, 1: data request, level. Held until d_ack.
REQ-011 SHALL have ports d_we (input, 1), d_addr (input, ADDR_W), d_wdata (input, DATA_W) and d_be (input, DATA_W/8): store enable, address, write data and byte enables.
REQ-012 SHALL have ports d_rdata (output, DATA_W) and d_ack (output, 1): load data, and the one-cycle completion pulse for data requests.
REQ-013 SHALL have ports m_req (output, 1), m_we (output, 1), m_addr (output, ADDR_W), m_wdata (output, DATA_W) and m_be (output, DATA_W/8): shared single-port memory request.
REQ-014 SHALL have ports m_rdata (input, DATA_W) and m_ready (input, 1): memory read data, and the completion qualifier (sampled only while m_req=1).
REQ-015 SHALL have port err, output, 1: sticky timeout flag. err_src (output, 1) gives the source of the last timeout: 0 = fetch, 1 = data.

Function
REQ-016 SHALL implement an FSM with states IDLE, BUSY_I, BUSY_D, RESP. Every output SHALL be driven from a register.
REQ-017 In IDLE, if neither if_req nor d_req is asserted, the FSM SHALL stay in IDLE with m_req=0.
REQ-018 In IDLE, if exactly one request is asserted, that requester SHALL be granted: BUSY_I for if_req, BUSY_D for d_req.
REQ-019 In IDLE, if both requests are asserted, the grant SHALL go to the requester not granted last (last_grant register, reset value 0 = fetch, so data wins first).
REQ-020 On grant, the address, we, wdata and be SHALL be latched into the m_* registers. Changes on the requester inputs while BUSY SHALL be ignored. For fetch grants, m_we=0 and m_be=all ones.
REQ-021 m_req SHALL be 1 in every BUSY cycle and 0 in every other state.
REQ-022 In BUSY, a cycle with m_ready=1 SHALL capture m_rdata into if_rdata or d_rdata (granted side only) and move the FSM to RESP.
REQ-023 On stores, d_rdata SHALL hold its previous value.
REQ-024 In RESP, the granted side's ack SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-025 Minimum latency: request sampled in IDLE at cycle N, m_req at N+1, m_ready at N+1, ack at N+2, next grant decided at N+3.
REQ-026 A wait counter (8 bits) SHALL clear on entry to BUSY and increment each BUSY cycle with m_ready=0.
REQ-027 When the wait counter equals TIMEOUT with m_ready=0, the FSM SHALL abort to RESP with the granted rdata forced to 0, set err=1, and set err_src.
REQ-028 A simultaneous m_ready=1 on the timeout cycle SHALL count as normal completion: no error, data captured.
REQ-029 err SHALL clear only on reset. err_src SHALL be updated on each new timeout.
REQ-030 if_ack and d_ack SHALL never both be 1 in the same cycle.
REQ-031 The other requester's pending request SHALL wait, unaffected, until IDLE.
REQ-032 Requests deasserted before a grant SHALL be dropped silently.

Reset
REQ-033 rst_n=1 SHALL immediately force state IDLE, all outputs 0, wait counter 0, last_grant 0, err 0 and err_src 0, including mid-transaction.
REQ-034 An in-flight memory access aborted by reset SHALL produce no ack.
REQ-035 Operation SHALL resume on the first rising edge after rst_n=0.

Verification
REQ-036 Single fetch: if_req=1, if_addr=0x40, m_ready tied 1, m_rdata=0x00500093 -> m_req at N+1 with m_addr=0x40, if_ack at N+2 with if_rdata=0x00500093, d_ack=0 throughout.
REQ-037 Store with byte enables: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=0x3, m_ready delayed 3 cycles -> m_req high 4 cycles with stable m_* values, d_ack one cycle after m_ready, d_rdata unchanged.
REQ-038 Contention: if_req and d_req both held high for 4 transactions -> grant order D, I, D, I, with no ack overlap.
REQ-039 Timeout: TIMEOUT=4, d_req=1, m_ready=0 -> d_ack 1 cycle after the 4th BUSY wait cycle, d_rdata=0, err=1, err_src=1. A following fetch still completes.
REQ-040 Reset mid-operation: assert rst_n during BUSY_I -> same cycle m_req=0, no if_ack. After release, a held if_req is re-granted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between an instruction
// fetch port and a data port. Each grant runs one access: IDLE picks a
// requester, BUSY holds the request until m_ready or a wait timeout, RESP
// pulses the ack, and the FSM then returns to IDLE. Every output comes from
// a flop, so the requesters and the memory see glitch-free signals.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,      // active-high asynchronous reset

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,

    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_be,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ready,

    output logic                err,
    output logic                err_src
);

    localparam int BE_W = DATA_W / 8;

    // The wait counter reaches TIMEOUT at the end of the TIMEOUT-th stalled
    // cycle, so the abort is taken while the counter still holds TIMEOUT-1.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state_q,      state_d;
    logic              last_grant_q, last_grant_d;   // 0 = fetch, 1 = data
    logic [7:0]        wait_cnt_q,   wait_cnt_d;
    logic              m_req_q,      m_req_d;
    logic              m_we_q,       m_we_d;
    logic [ADDR_W-1:0] m_addr_q,     m_addr_d;
    logic [DATA_W-1:0] m_wdata_q,    m_wdata_d;
    logic [BE_W-1:0]   m_be_q,       m_be_d;
    logic [DATA_W-1:0] if_rdata_q,   if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,    d_rdata_d;
    logic              if_ack_q,     if_ack_d;
    logic              d_ack_q,      d_ack_d;
    logic              err_q,        err_d;
    logic              err_src_q,    err_src_d;
    logic              grant_data;

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wait_cnt_d   = wait_cnt_q;
        m_req_d      = 1'b0;
        m_we_d       = m_we_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        m_be_d       = m_be_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        err_d        = err_q;
        err_src_d    = err_src_q;
        // Data wins when it is the only requester, or when both ask and
        // fetch was served last.
        grant_data   = d_req && (!if_req || !last_grant_q);

        unique case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    last_grant_d = grant_data;
                    state_d      = grant_data ? BUSY_D : BUSY_I;
                    m_req_d      = 1'b1;
                    wait_cnt_d   = 8'd0;
                    if (grant_data) begin
                        m_we_d    = d_we;
                        m_addr_d  = d_addr;
                        m_wdata_d = d_wdata;
                        m_be_d    = d_be;
                    end else begin
                        m_we_d    = 1'b0;
                        m_addr_d  = if_addr;
                        m_wdata_d = '0;
                        m_be_d    = '1;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (m_ready) begin
                    // Normal completion, including on the timeout cycle.
                    state_d = RESP;
                    if (state_q == BUSY_I) begin
                        if_rdata_d = m_rdata;
                        if_ack_d   = 1'b1;
                    end else begin
                        if (!m_we_q) begin
                            d_rdata_d = m_rdata;
                        end
                        d_ack_d = 1'b1;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // Memory never answered: finish the access with zero data
                    // and record who was stuck.
                    state_d   = RESP;
                    err_d     = 1'b1;
                    err_src_d = (state_q == BUSY_D);
                    if (state_q == BUSY_I) begin
                        if_rdata_d = '0;
                        if_ack_d   = 1'b1;
                    end else begin
                        d_rdata_d = '0;
                        d_ack_d   = 1'b1;
                    end
                end else begin
                    m_req_d    = 1'b1;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any in-flight access silently.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            wait_cnt_q   <= 8'd0;
            m_req_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            m_be_q       <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            err_q        <= 1'b0;
            err_src_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
            m_req_q      <= m_req_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            m_be_q       <= m_be_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            err_q        <= err_d;
            err_src_q    <= err_src_d;
        end
    end

    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign m_be     = m_be_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign if_ack   = if_ack_q;
    assign d_ack    = d_ack_q;
    assign err      = err_q;
    assign err_src  = err_src_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a driver issues fetch/data requests and pushes
// the expected accesses (in arbitration order) into a scoreboard; a memory
// responder answers with planned delays; a monitor checks the memory request
// and every ack against the scoreboard.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [3:0]    d_be;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [3:0]    m_be;
    logic [DW-1:0] m_rdata;
    logic          m_ready;
    logic          err;
    logic          err_src;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_rdata(m_rdata), .m_ready(m_ready),
        .err(err), .err_src(err_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          side;      // 0 = fetch, 1 = data
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        int          delay;
        bit          tmo;
        bit          err;
        bit          err_src;
    } exp_t;

    typedef struct {
        int          delay;
        logic [31:0] rdata;
    } plan_t;

    exp_t  exp_q[$];
    plan_t plan_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 0;

    // Reference state: what the requesters should observe.
    bit          last_grant_m = 0;
    bit          err_m        = 0;
    bit          err_src_m    = 0;
    logic [31:0] if_rdata_m   = '0;
    logic [31:0] d_rdata_m    = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // One memory access as the requester should see it.
    task automatic model_grant(input bit side, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input int delay, input logic [31:0] rd);
        exp_t  e;
        plan_t p;
        e.side  = side;
        e.we    = side ? we : 1'b0;
        e.addr  = addr;
        e.wdata = wdata;
        e.be    = side ? be : 4'hF;
        e.delay = delay;
        e.tmo   = (delay >= TMO);
        if (e.tmo) begin
            err_m     = 1'b1;
            err_src_m = side;
        end
        if (!side)
            if_rdata_m = e.tmo ? 32'h0 : rd;
        else if (e.tmo)
            d_rdata_m = 32'h0;
        else if (!we)
            d_rdata_m = rd;
        e.rdata   = side ? d_rdata_m : if_rdata_m;
        e.err     = err_m;
        e.err_src = err_src_m;
        last_grant_m = side;
        exp_q.push_back(e);
        p.delay = delay;
        p.rdata = rd;
        plan_q.push_back(p);
    endtask

    // Issue fetch and/or data requests, hold each until its ack.
    task automatic run_round(input bit use_i, input bit use_d,
                             input logic [31:0] ia, input int idly, input logic [31:0] ird,
                             input bit dwe, input logic [31:0] da, input logic [31:0] dw,
                             input logic [3:0] dbe, input int ddly, input logic [31:0] drd,
                             input bit pulse_i);
        bit first_d, pend_i, pend_d, cur;
        int guard, pulse_state;
        @(negedge clk);
        if (use_i) begin if_req = 1'b1; if_addr = ia; end
        if (use_d) begin d_req = 1'b1; d_we = dwe; d_addr = da; d_wdata = dw; d_be = dbe; end
        first_d = use_d && (!use_i || !last_grant_m);
        if (first_d) begin
            model_grant(1'b1, dwe, da, dw, dbe, ddly, drd);
            if (use_i) model_grant(1'b0, 1'b0, ia, 32'h0, 4'hF, idly, ird);
        end else begin
            model_grant(1'b0, 1'b0, ia, 32'h0, 4'hF, idly, ird);
            if (use_d) model_grant(1'b1, dwe, da, dw, dbe, ddly, drd);
        end
        cur = first_d;
        pend_i = use_i;
        pend_d = use_d;
        pulse_state = 0;
        guard = 0;
        @(negedge clk);
        chk("grant_latency", m_req, 1);
        while ((pend_i || pend_d) && guard < 100) begin
            if (if_ack && pend_i) begin if_req = 1'b0; pend_i = 0; cur = 1; end
            if (d_ack && pend_d) begin d_req = 1'b0; pend_d = 0; cur = 0; end
            if (m_req) begin
                // Inputs of the side being served must be ignored now.
                if (cur) begin
                    d_addr = $urandom; d_wdata = $urandom;
                    d_be = 4'($urandom); d_we = 1'($urandom_range(0, 1));
                end else begin
                    if_addr = $urandom;
                end
            end
            if (pulse_i && pulse_state == 0 && m_req) begin
                if_req = 1'b1; if_addr = $urandom; pulse_state = 1;
            end else if (pulse_state == 1) begin
                if_req = 1'b0; pulse_state = 2;
            end
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("round_done_in_time", 0, 1);
    endtask

    // Memory model: answers each access after its planned number of stalls.
    initial begin
        bit    resp_active = 0;
        int    rcnt = 0;
        plan_t cur_plan;
        m_ready = 1'b0;
        m_rdata = '0;
        cur_plan.delay = 0;
        cur_plan.rdata = '0;
        forever begin
            @(negedge clk);
            if (m_req) begin
                if (!resp_active) begin
                    resp_active = 1;
                    rcnt = 0;
                    if (plan_q.size() > 0) cur_plan = plan_q.pop_front();
                    else begin cur_plan.delay = 1000; cur_plan.rdata = '0; end
                end
                m_ready = (rcnt == cur_plan.delay);
                m_rdata = m_ready ? cur_plan.rdata : $urandom;
                rcnt++;
            end else begin
                resp_active = 0;
                m_ready = 1'b0;
                m_rdata = $urandom;
            end
        end
    end

    // Monitor: checks the memory request each BUSY cycle and every ack.
    initial begin
        int   busy_cnt = 0;
        bit   prev_mreq = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                busy_cnt = 0;
                prev_mreq = 0;
            end else begin
                if (m_req) begin
                    if (exp_q.size() == 0) chk("unexpected_m_req", 1, 0);
                    else begin
                        chk("m_we", m_we, exp_q[0].we);
                        chk("m_addr", m_addr, exp_q[0].addr);
                        chk("m_be", m_be, exp_q[0].be);
                        if (exp_q[0].we) chk("m_wdata", m_wdata, exp_q[0].wdata);
                    end
                    busy_cnt++;
                end
                if (if_ack || d_ack) begin
                    chk("ack_exclusive", if_ack && d_ack, 0);
                    if (exp_q.size() == 0) chk("unexpected_ack", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("ack_side", d_ack, e.side);
                        chk("rdata", e.side ? d_rdata : if_rdata, e.rdata);
                        chk("err", err, e.err);
                        chk("err_src", err_src, e.err_src);
                        chk("busy_cycles", busy_cnt, e.tmo ? TMO : e.delay + 1);
                        chk("ack_follows_busy", prev_mreq, 1);
                    end
                    busy_cnt = 0;
                end
                prev_mreq = m_req;
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b1;
        if_req = 0; if_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
        repeat (3) @(negedge clk);
        chk("reset_m_req", m_req, 0);
        chk("reset_if_ack", if_ack, 0);
        chk("reset_d_ack", d_ack, 0);
        chk("reset_err", err, 0);
        chk("reset_m_be", m_be, 0);
        rst = 1'b0;
        mon_en = 1;

        // Contention: both held for two rounds -> D, I, D, I.
        run_round(1, 1, 32'h1000, 0, 32'hA1A1_0001, 0, 32'h2000, 32'h0, 4'hF, 1, 32'hB2B2_0002, 0);
        run_round(1, 1, 32'h1004, 2, 32'hA1A1_0003, 0, 32'h2004, 32'h0, 4'hF, 0, 32'hB2B2_0004, 0);
        // Single fetch with zero wait.
        run_round(1, 0, 32'h40, 0, 32'h0050_0093, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0);
        // Store with byte enables, ready on the 4th BUSY cycle (timeout edge).
        run_round(0, 1, 32'h0, 0, 32'h0, 1, 32'h100, 32'hDEAD_BEEF, 4'h3, 3, 32'h1234_5678, 0);
        // Load that times out, then a fetch that still completes.
        run_round(0, 1, 32'h0, 0, 32'h0, 0, 32'h200, 32'h0, 4'hF, 10, 32'h5555_AAAA, 0);
        run_round(1, 0, 32'h44, 1, 32'h0000_0013, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0);
        // A fetch request pulsed while data is busy must be dropped.
        run_round(0, 1, 32'h0, 0, 32'h0, 0, 32'h300, 32'h0, 4'hF, 2, 32'h7777_8888, 1);

        for (int r = 0; r < 40; r++) begin
            bit ui, ud;
            ui = 1'($urandom_range(0, 1));
            ud = 1'($urandom_range(0, 1));
            if (!ui && !ud) ud = 1;
            run_round(ui, ud, $urandom, $urandom_range(0, 6), $urandom,
                      1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                      $urandom_range(0, 6), $urandom, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of a fetch: no ack, re-grant after release.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h80;
        model_grant(1'b0, 1'b0, 32'h80, 32'h0, 4'hF, 20, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("busy_before_reset", m_req, 1);
        #2;
        mon_en = 0;
        rst = 1'b1;
        #1;
        chk("rst_m_req_now", m_req, 0);
        chk("rst_if_ack_now", if_ack, 0);
        chk("rst_err_now", err, 0);
        chk("rst_err_src_now", err_src, 0);
        chk("rst_m_addr_now", m_addr, 0);
        exp_q.delete();
        plan_q.delete();
        last_grant_m = 0; err_m = 0; err_src_m = 0; if_rdata_m = '0; d_rdata_m = '0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_if_ack", if_ack, 0);
        end
        model_grant(1'b0, 1'b0, 32'h80, 32'h0, 4'hF, 1, 32'hCAFE_F00D);
        rst = 1'b0;
        mon_en = 1;
        @(negedge clk);
        chk("regrant_after_reset", m_req, 1);
        guard = 0;
        while (!if_ack && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("regrant_ack_in_time", 0, 1);
        if_req = 1'b0;

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
